// File: rtl/bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package bit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_subtractor_cell.sv
// One-bit full subtractor: a + ~b + carryin, built from gate primitives.
module serial_sub_cell (
  input  logic      a,
  input  logic      b,
  input  logic      carryin,
  output wire logic diff,
  output wire logic carryout
);

  wire w_bn;
  wire w_axb;
  wire w_gen;
  wire w_prop;

  not u_inv  (w_bn, b);
  xor u_x1   (w_axb, a, w_bn);
  xor u_x2   (diff, w_axb, carryin);
  and u_a1   (w_gen, a, w_bn);
  and u_a2   (w_prop, w_axb, carryin);
  or  u_o1   (carryout, w_gen, w_prop);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: a - b computed LSB first as a + ~b + 1 over WIDTH cycles.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_partial;
  logic [WIDTH-1:0] r_difference;
  logic             r_carry;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic             w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_partial_next;

  serial_sub_cell u_cell (
    .a        (r_sa[0]),
    .b        (r_sb[0]),
    .carryin  (r_carry),
    .diff     (w_s),
    .carryout (w_cout)
  );

  // start is honoured from DONE as well, giving back-to-back operation.
  assign w_accept       = start && (r_state == IDLE || r_state == DONE);
  assign w_last         = (r_state == RUN) && (r_count == CW'(WIDTH - 1));
  assign w_partial_next = {w_s, r_partial[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_partial    <= '0;
      r_carry      <= 1'b0;
      r_count      <= '0;
      r_difference <= '0;
      r_borrow     <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_carry <= 1'b1;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_sa      <= r_sa >> 1;
      r_sb      <= r_sb >> 1;
      r_partial <= w_partial_next;
      r_carry   <= w_cout;
      r_count   <= r_count + CW'(1);
      if (w_last) begin
        r_difference <= w_partial_next;
        r_borrow     <= ~w_cout;
      end
    end
  end

  assign difference = r_difference;
  assign borrowout  = r_borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_overflow;

  // On the last bit the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_last) r_overflow <= r_carry ^ w_cout;
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor (WIDTH=8); checks overflow when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_bit_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrowout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  exp_t             expQ[$];
  int               tests = 0;
  int               fails = 0;
  int               cycle = 0;
  logic [WIDTH-1:0] lastDiff = '0;

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrowout  (borrowout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: plain modular and signed integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int due);
    exp_t e;
    int   sd;
    e.diff   = WIDTH'((int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH));
    e.borrow = int'(x) < int'(y);
    sd       = int'($signed(x)) - int'($signed(y));
    e.ovf    = (sd > (1 << (WIDTH - 1)) - 1) || (sd < -(1 << (WIDTH - 1)));
    e.due    = due;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("difference", 32'(difference), 32'(e.diff));
        checkOutput("borrowout", 32'(borrowout), 32'(e.borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
`endif
        checkOutput("done_latency", 32'(cycle), 32'(e.due));
        lastDiff = e.diff;
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 4 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    waitIdle();
    a     = x;
    b     = y;
    start = 1'b1;
    expQ.push_back(model(x, y, cycle + 1 + WIDTH));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] bx[6];
    logic [WIDTH-1:0] by[6];
    bx = '{8'h00, 8'hAA, 8'h80, 8'h7F, 8'hFF, 8'h00};
    by = '{8'h01, 8'hAA, 8'h01, 8'hFF, 8'h00, 8'h80};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_difference", 32'(difference), 32'd0);
    checkOutput("reset_borrowout", 32'(borrowout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
`endif
    reset = 1'b0;

    // 5 - 3: busy width and done position.
    applyStimulus(8'd5, 8'd3);
    n = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("busy_cycles", 32'(n), 32'(WIDTH));
    checkOutput("done_after_busy", 32'(done), 32'd1);

    applyStimulus(8'd3, 8'd5);
    applyStimulus(8'h80, 8'h01);

    // A start during RUN must be ignored.
    applyStimulus(8'd9, 8'd4);
    repeat (3) @(negedge clk);
    checkOutput("diff_hold_in_run", 32'(difference), 32'(lastDiff));
    a     = 8'd0;
    b     = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);

    // start held through DONE: back-to-back operation.
    waitIdle();
    a     = 8'd7;
    b     = 8'd7;
    start = 1'b1;
    expQ.push_back(model(8'd7, 8'd7, cycle + 1 + WIDTH));
    expQ.push_back(model(8'd0, 8'd1, cycle + 2 + 2 * WIDTH));
    @(posedge clk);
    #1;
    a = 8'd0;
    b = 8'd1;
    repeat (WIDTH) @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset on the fourth RUN cycle aborts without a done pulse.
    applyStimulus(8'd200, 8'd13);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_difference", 32'(difference), 32'd0);
    checkOutput("abort_borrowout", 32'(borrowout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
`endif
    expQ.delete();
    lastDiff = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * WIDTH) @(negedge clk);

    applyStimulus(8'd100, 8'd58);

    for (int i = 0; i < 6; i++) applyStimulus(bx[i], by[i]);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom));
    end

    for (int i = 0; i < 4 * WIDTH; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
